// File: rtl/escalonador_processos_if.sv
// Bundles the signals between the scheduler and the CPU/OS side.
//   master : CPU side (drives retire/create/terminate/IO events, receives switch info)
//   slave  : scheduler (escalonador_processos)
// Ports:
//   instr_valid, pc_retorno         retired instruction and resume PC of the running process
//   cria_valid, cria_pc             process creation request and its start PC
//   cria_ack, cria_erro             one-cycle creation result pulses
//   fim_processo, io_bloqueio       running process terminates / blocks on IO
//   io_libera, io_libera_id         unblock request and target slot
//   troca, pc_novo                  context-switch pulse and PC to load
//   processo_atual, ocioso          running slot, no ready process
//   num_ativos, quantum_restante    non-free slot count, instructions left in slice
interface escalonador_processos_if #(
    parameter int N_PROC = 4,
    parameter int PC_W   = 32
);
    localparam int ID_W = $clog2(N_PROC);

    logic            instr_valid;
    logic [PC_W-1:0] pc_retorno;
    logic            cria_valid;
    logic [PC_W-1:0] cria_pc;
    logic            cria_ack;
    logic            cria_erro;
    logic            fim_processo;
    logic            io_bloqueio;
    logic            io_libera;
    logic [ID_W-1:0] io_libera_id;
    logic            troca;
    logic [PC_W-1:0] pc_novo;
    logic [ID_W-1:0] processo_atual;
    logic            ocioso;
    logic [ID_W:0]   num_ativos;
    logic [7:0]      quantum_restante;

    modport master (
        output instr_valid, pc_retorno, cria_valid, cria_pc, fim_processo,
               io_bloqueio, io_libera, io_libera_id,
        input  cria_ack, cria_erro, troca, pc_novo, processo_atual, ocioso,
               num_ativos, quantum_restante
    );

    modport slave (
        input  instr_valid, pc_retorno, cria_valid, cria_pc, fim_processo,
               io_bloqueio, io_libera, io_libera_id,
        output cria_ack, cria_erro, troca, pc_novo, processo_atual, ocioso,
               num_ativos, quantum_restante
    );
endinterface

// File: rtl/escalonador_processos.sv
// Round-robin process scheduler with a fixed instruction quantum.
// Keeps a table of N_PROC slots (state + saved PC), picks the next ready
// process after quantum expiry, termination or IO blocking, and signals
// a context switch with troca/pc_novo.
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous, active-high
//   bus    escalonador_processos_if.slave (see interface file for signal list)
//
// FSM states:
//   state          | meaning
//   ST_OCIOSO      | no process running, waiting for a slot to become PRONTO
//   ST_EXECUTANDO  | a process runs; counts its quantum, watches fim/io events
//   ST_SELECIONA   | choose next PRONTO slot round-robin (switch on next edge)
module escalonador_processos #(
    parameter int N_PROC  = 4,
    parameter int QUANTUM = 16,
    parameter int PC_W    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    escalonador_processos_if.slave bus
);
    localparam int ID_W = $clog2(N_PROC);

    typedef enum logic [1:0] {ST_OCIOSO, ST_EXECUTANDO, ST_SELECIONA} fsm_t;
    typedef enum logic [1:0] {SL_LIVRE, SL_PRONTO, SL_BLOQUEADO, SL_EXECUTANDO} slot_t;

    fsm_t            state, state_n;
    slot_t           tab   [N_PROC];
    slot_t           tab_n [N_PROC];
    logic [PC_W-1:0] pcs   [N_PROC];
    logic [PC_W-1:0] pcs_n [N_PROC];
    logic [ID_W-1:0] atual, atual_n;
    logic [7:0]      quantum, quantum_n;
    logic            troca, troca_n;
    logic [PC_W-1:0] pc_novo, pc_novo_n;
    logic            ack, ack_n;
    logic            erro, erro_n;
    logic [ID_W:0]   ativos, ativos_n;

    logic            cria_hit;
    logic [ID_W-1:0] cria_idx;
    logic            sel_hit;
    logic [ID_W-1:0] sel_idx;
    logic [ID_W-1:0] cand;
    logic            pronto_any;

    always_comb begin
        state_n   = state;
        atual_n   = atual;
        quantum_n = quantum;
        troca_n   = 1'b0;
        pc_novo_n = pc_novo;
        ack_n     = 1'b0;
        erro_n    = 1'b0;
        cria_hit  = 1'b0;
        cria_idx  = '0;
        sel_hit   = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        pronto_any = 1'b0;
        ativos_n  = '0;
        for (int i = 0; i < N_PROC; i++) begin
            tab_n[i] = tab[i];
            pcs_n[i] = pcs[i];
        end

        // Events of the running process; fim beats io_bloqueio beats expiry.
        if (state == ST_EXECUTANDO) begin
            if (bus.fim_processo) begin
                tab_n[atual] = SL_LIVRE;
                state_n      = ST_SELECIONA;
            end else if (bus.io_bloqueio) begin
                tab_n[atual] = SL_BLOQUEADO;
                pcs_n[atual] = bus.pc_retorno;
                state_n      = ST_SELECIONA;
            end else if (bus.instr_valid) begin
                quantum_n = quantum - 8'd1;
                if (quantum == 8'd1) begin
                    tab_n[atual] = SL_PRONTO;
                    pcs_n[atual] = bus.pc_retorno;
                    state_n      = ST_SELECIONA;
                end
            end
        end

        // Creation and unblock look at the registered table, so they never
        // collide with the running slot's own update above.
        if (bus.cria_valid) begin
            for (int i = 0; i < N_PROC; i++) begin
                if (!cria_hit && tab[i] == SL_LIVRE) begin
                    cria_hit = 1'b1;
                    cria_idx = ID_W'(i);
                end
            end
            if (cria_hit) begin
                tab_n[cria_idx] = SL_PRONTO;
                pcs_n[cria_idx] = bus.cria_pc;
                ack_n           = 1'b1;
            end else begin
                erro_n = 1'b1;
            end
        end

        if (bus.io_libera && int'(bus.io_libera_id) < N_PROC &&
            tab[bus.io_libera_id] == SL_BLOQUEADO) begin
            tab_n[bus.io_libera_id] = SL_PRONTO;
        end

        for (int i = 0; i < N_PROC; i++) begin
            if (tab[i] == SL_PRONTO) pronto_any = 1'b1;
        end

        case (state)
            ST_OCIOSO: begin
                if (pronto_any) state_n = ST_SELECIONA;
            end
            ST_SELECIONA: begin
                // Selection sees this cycle's creations/unblocks; the current
                // slot is checked last (k == N_PROC).
                for (int k = 1; k <= N_PROC; k++) begin
                    cand = ID_W'((int'(atual) + k) % N_PROC);
                    if (!sel_hit && tab_n[cand] == SL_PRONTO) begin
                        sel_hit = 1'b1;
                        sel_idx = cand;
                    end
                end
                if (sel_hit) begin
                    tab_n[sel_idx] = SL_EXECUTANDO;
                    pc_novo_n      = pcs_n[sel_idx];
                    troca_n        = 1'b1;
                    quantum_n      = 8'(QUANTUM);
                    atual_n        = sel_idx;
                    state_n        = ST_EXECUTANDO;
                end else begin
                    state_n = ST_OCIOSO;
                end
            end
            default: ;
        endcase

        for (int i = 0; i < N_PROC; i++) begin
            if (tab_n[i] != SL_LIVRE) ativos_n = ativos_n + (ID_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_OCIOSO;
            atual   <= '0;
            quantum <= '0;
            troca   <= 1'b0;
            pc_novo <= '0;
            ack     <= 1'b0;
            erro    <= 1'b0;
            ativos  <= '0;
            for (int i = 0; i < N_PROC; i++) begin
                tab[i] <= SL_LIVRE;
                pcs[i] <= '0;
            end
        end else begin
            state   <= state_n;
            atual   <= atual_n;
            quantum <= quantum_n;
            troca   <= troca_n;
            pc_novo <= pc_novo_n;
            ack     <= ack_n;
            erro    <= erro_n;
            ativos  <= ativos_n;
            for (int i = 0; i < N_PROC; i++) begin
                tab[i] <= tab_n[i];
                pcs[i] <= pcs_n[i];
            end
        end
    end

    assign bus.cria_ack         = ack;
    assign bus.cria_erro        = erro;
    assign bus.troca            = troca;
    assign bus.pc_novo          = pc_novo;
    assign bus.processo_atual   = atual;
    assign bus.ocioso           = (state == ST_OCIOSO);
    assign bus.num_ativos       = ativos;
    assign bus.quantum_restante = quantum;
endmodule

// File: doc/escalonador_processos.md
ESCALONADOR_PROCESSOS -- requirements
Module: escalonador_processos

Interface
REQ-001 SHALL have parameter N_PROC, default 4, number of process slots (2..16).
REQ-002 SHALL have parameter QUANTUM, default 16, instructions per time slice (1..255).
REQ-003 SHALL have parameter PC_W, default 32, PC width; ID_W = clog2(N_PROC).
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high.
REQ-006 SHALL have port instr_valid  in  1  one instruction retired this cycle.
REQ-007 SHALL have port pc_retorno  in  PC_W  resume PC of the running process.
REQ-008 SHALL have ports cria_valid  in  1 and cria_pc  in  PC_W, which create a process at cria_pc.
REQ-009 SHALL have ports cria_ack  out  1 and cria_erro  out  1, one-cycle creation result pulses.
REQ-010 SHALL have port fim_processo  in  1  running process terminates.
REQ-011 SHALL have port io_bloqueio  in  1  running process blocks on IO.
REQ-012 SHALL have ports io_libera  in  1 and io_libera_id  in  ID_W, which unblock a process.
REQ-013 SHALL have ports troca  out  1 (one-cycle context-switch pulse) and pc_novo  out  PC_W (PC to load when troca=1).
REQ-014 SHALL have port processo_atual  out  ID_W  running slot.
REQ-015 SHALL have port ocioso  out  1  no ready process.
REQ-016 SHALL have port num_ativos  out  ID_W+1  count of non-free slots.
REQ-017 SHALL have port quantum_restante  out  8  instructions left in slice.

Function
REQ-018 SHALL keep per slot a state (LIVRE, PRONTO, BLOQUEADO, EXECUTANDO) and a saved PC.
REQ-019 SHALL implement FSM states OCIOSO, EXECUTANDO, SELECIONA.
REQ-020 Creation: in any FSM state, cria_valid SHALL claim the lowest-index LIVRE slot (set PRONTO, PC=cria_pc), and cria_ack SHALL pulse the next cycle.
REQ-021 Creation with no LIVRE slot SHALL leave the table unchanged and pulse cria_erro the next cycle.
REQ-022 In EXECUTANDO, each instr_valid SHALL decrement quantum_restante.
REQ-023 instr_valid with quantum_restante=1 SHALL be a quantum expiry: save pc_retorno, set running slot PRONTO, go SELECIONA.
REQ-024 fim_processo in EXECUTANDO SHALL set running slot LIVRE and go SELECIONA.
REQ-025 io_bloqueio in EXECUTANDO SHALL save pc_retorno, set running slot BLOQUEADO, and go SELECIONA.
REQ-026 Same-cycle event priority SHALL be reset > fim_processo > io_bloqueio > quantum expiry.
REQ-027 SELECIONA SHALL pick the first PRONTO slot searching round-robin from processo_atual+1 (mod N_PROC), wrapping to processo_atual itself last.
REQ-028 On a successful SELECIONA, the next edge SHALL set troca=1 for exactly one cycle, set pc_novo to the slot PC, set the slot EXECUTANDO, reload quantum_restante=QUANTUM, update processo_atual, and go to EXECUTANDO; troca thus pulses 2 cycles after the triggering event cycle.
REQ-029 A preempted sole-ready process SHALL be reselected, with troca pulsing and pc_novo equal to its saved PC.
REQ-030 SELECIONA with no PRONTO slot SHALL go to OCIOSO with ocioso=1; processo_atual SHALL hold.
REQ-031 In OCIOSO, a creation or unblock that makes a slot PRONTO SHALL move the FSM to SELECIONA on the following edge.
REQ-032 io_libera SHALL set slot io_libera_id PRONTO only if that slot is BLOQUEADO; otherwise it SHALL be ignored.
REQ-033 io_libera targeting the slot that is blocking in the same cycle SHALL be ignored, leaving the slot BLOQUEADO.
REQ-034 Table updates from creation and unblock in the SELECIONA cycle SHALL be visible to that cycle's selection.
REQ-035 instr_valid, fim_processo and io_bloqueio SHALL be ignored outside EXECUTANDO.
REQ-036 io_libera_id >= N_PROC SHALL be ignored.
REQ-037 num_ativos SHALL equal the count of slots not LIVRE, updated the edge after each change.

Reset
REQ-038 Reset SHALL, on the next rising edge: set all slots LIVRE with PC 0, FSM OCIOSO, troca=0, pc_novo=0, processo_atual=0, ocioso=1, num_ativos=0, quantum_restante=0, cria_ack=0, cria_erro=0.
REQ-039 Reset asserted mid-SELECIONA or mid-slice SHALL abort without a troca pulse.

Verification (N_PROC=4, QUANTUM=4)
REQ-040 Reset, then cria_valid with cria_pc=100 -> cria_ack at t+1, troca at t+3, pc_novo=100, processo_atual=0, quantum_restante=4.
REQ-041 Slots 0 (PC 100) and 1 (PC 400) exist, slot 0 running, 4 instr_valid with pc_retorno=104 -> troca pulses, pc_novo=400, processo_atual=1; next expiry returns pc_novo=104.
REQ-042 5 creations with 4 slots free -> 4 cria_ack pulses, then cria_erro, num_ativos=4.
REQ-043 Sole process does io_bloqueio with pc_retorno=120 -> ocioso=1; io_libera with id 0 -> troca with pc_novo=120.
REQ-044 fim_processo and io_bloqueio in the same cycle -> slot LIVRE, num_ativos decrements.
REQ-045 Reset asserted the cycle after an expiry -> no troca pulse, all outputs at reset values.
